// File: rtl/k2_pkg.sv
// k2_pkg: shared FSM states, instruction field map and decoded-instruction type for the K2 sequencer
package k2_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_STEP_WAIT,
    S_HALT
  } state_t;
  localparam int J_BIT = 7;
  localparam int C_BIT = 6;
  localparam int D_HI = 5;
  localparam int D_LO = 4;
  localparam int SREG_BIT = 3;
  localparam int IMM_HI = 2;
  localparam logic [1:0] DST_RA = 2'b00;
  localparam logic [1:0] DST_RB = 2'b01;
  localparam logic [1:0] DST_RO = 2'b10;
  localparam logic [1:0] DST_NONE = 2'b11;
  typedef struct packed {
    logic is_data;
    logic is_jmp;
    logic is_jcf;
    logic is_hlt;
    logic [1:0] dst;
    logic sreg;
    logic [2:0] imm;
  } decoded_t;
endpackage

// File: rtl/k2_instr_decode.sv
// k2_instr_decode: splits an instruction word into instruction class flags and datapath fields
module k2_instr_decode
  import k2_pkg::*;
#(
  parameter int INSTR_W = 8
) (
  input  logic [INSTR_W-1:0] ir,
  output decoded_t           dec
);
  logic j, c, no_dst;
  always_comb begin
    j = ir[J_BIT];
    c = ir[C_BIT];
    no_dst = ir[D_HI:D_LO] == DST_NONE;
    dec.dst = ir[D_HI:D_LO];
    dec.sreg = ir[SREG_BIT];
    dec.imm = ir[IMM_HI:0];
    dec.is_data = !j && !no_dst;
    dec.is_jmp = j && !c && !no_dst;
    dec.is_jcf = j && c && !no_dst;
    dec.is_hlt = j && no_dst;
  end
endmodule

// File: rtl/k2_sequencer.sv
// k2_sequencer: fetch/execute controller owning the PC, instruction fetch, decode, carry jumps and run/halt/step control
module k2_sequencer
  import k2_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int INSTR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               halt_req,
  input  logic               step_mode,
  input  logic               step,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_req,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               cf,
  input  logic               zf,
  output logic               dp_we,
  output logic [1:0]         dp_dst,
  output logic               dp_sreg,
  output logic [2:0]         dp_imm,
  output logic               running,
  output logic               halted
);
  state_t state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [INSTR_W-1:0] ir;
  logic cf_q, zf_q, jump;
  decoded_t dec;
  k2_instr_decode #(.INSTR_W(INSTR_W)) u_dec (
    .ir (ir),
    .dec(dec)
  );
  always_comb begin
    jump = dec.is_jmp || (dec.is_jcf && cf_q);
    pc_nxt = jump ? ADDR_W'(dec.imm) : pc + ADDR_W'(1);
    state_nxt = state;
    case (state)
      S_IDLE, S_HALT: state_nxt = start ? S_FETCH : state;
      S_FETCH:        state_nxt = imem_ready ? S_EXEC : S_FETCH;
      S_EXEC:         state_nxt = (dec.is_hlt || halt_req) ? S_HALT : step_mode ? S_STEP_WAIT : S_FETCH;
      S_STEP_WAIT:    state_nxt = halt_req ? S_HALT : step ? S_FETCH : S_STEP_WAIT;
      default:        state_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      pc <= '0;
      ir <= '0;
      cf_q <= 1'b0;
      zf_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH && imem_ready) ir <= imem_data;
      if (state == S_EXEC) begin
        pc <= pc_nxt;
        if (dec.is_data) begin
          cf_q <= cf;
          zf_q <= zf;
        end else if (dec.is_jcf && cf_q) begin
          cf_q <= 1'b0;
        end
      end
    end
  end
  assign imem_addr = pc;
  assign imem_req = state == S_FETCH;
  assign dp_we = state == S_EXEC && dec.is_data;
  assign dp_dst = dec.dst;
  assign dp_sreg = dec.sreg;
  assign dp_imm = dec.imm;
  assign running = state inside {S_FETCH, S_EXEC, S_STEP_WAIT};
  assign halted = state == S_HALT;
endmodule

// File: tb/tb_k2_sequencer.sv
// tb_k2_sequencer: directed and randomized checking of k2_sequencer against an instruction-level reference model
module tb_k2_sequencer;
  localparam int AW = 4;
  logic clk = 1'b0;
  logic rst, start, halt_req, step_mode, step, imem_ready, cf, zf;
  logic [AW-1:0] imem_addr;
  logic imem_req;
  logic [7:0] imem_data;
  logic dp_we, dp_sreg, running, halted;
  logic [1:0] dp_dst;
  logic [2:0] dp_imm;
  logic [7:0] mem [16];
  int n_checks = 0;
  int n_fail = 0;
  int m_pc;
  bit m_cf;
  bit m_halted;
  bit noise;
  int sw_mode;
  assign imem_data = mem[imem_addr];
  always #5 clk = ~clk;
  k2_sequencer #(.ADDR_W(AW), .INSTR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req), .step_mode(step_mode), .step(step),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_ready(imem_ready), .imem_data(imem_data),
    .cf(cf), .zf(zf), .dp_we(dp_we), .dp_dst(dp_dst), .dp_sreg(dp_sreg), .dp_imm(dp_imm),
    .running(running), .halted(halted)
  );
  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic noisy();
    if (noise) begin
      halt_req = $urandom_range(0, 3) == 0;
      step = 1'($urandom_range(0, 1));
      start = 1'($urandom_range(0, 1));
    end
  endtask
  task automatic step_wait();
    int idle = $urandom_range(0, 3);
    int act;
    act = sw_mode != 0 ? sw_mode : ($urandom_range(0, 5) == 0 ? 2 : 1);
    for (int i = 0; i <= idle; i++) begin
      step = i == idle;
      halt_req = i == idle && act == 2;
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      imem_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      check("sw_run", running, 1);
      check("sw_halted", halted, 0);
      check("sw_req", imem_req, 0);
      check("sw_we", dp_we, 0);
      check("sw_pc", imem_addr, m_pc);
      tick();
    end
    step = 0;
    halt_req = 0;
    start = 0;
    if (act == 2) begin
      m_halted = 1;
      check("sw_to_halt", halted, 1);
      check("sw_halt_run", running, 0);
    end
  endtask
  task automatic run_instr(int waits, int cfv);
    logic [7:0] ins;
    bit j, c, wr, hlt, hreq, cf_s;
    logic [1:0] d;
    for (int w = 0; w <= waits; w++) begin
      imem_ready = w == waits;
      noisy();
      check("fetch_req", imem_req, 1);
      check("fetch_addr", imem_addr, m_pc);
      check("fetch_we", dp_we, 0);
      check("fetch_run", running, 1);
      tick();
    end
    ins = mem[m_pc];
    j = ins[7];
    c = ins[6];
    d = ins[5:4];
    wr = !j && d != 2'b11;
    hlt = j && d == 2'b11;
    check("exec_we", dp_we, wr);
    check("exec_dst", dp_dst, d);
    check("exec_sreg", dp_sreg, ins[3]);
    check("exec_imm", dp_imm, ins[2:0]);
    check("exec_req", imem_req, 0);
    check("exec_run", running, 1);
    imem_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    cf_s = cfv < 0 ? 1'($urandom_range(0, 1)) : cfv[0];
    cf = cf_s;
    zf = 1'($urandom_range(0, 1));
    noisy();
    hreq = halt_req;
    tick();
    halt_req = 0;
    step = 0;
    start = 0;
    if (j && !hlt && (!c || m_cf)) begin
      m_pc = ins[2:0];
      if (c) m_cf = 0;
    end else begin
      m_pc = (m_pc + 1) % 16;
    end
    if (wr) m_cf = cf_s;
    if (hlt || hreq) begin
      m_halted = 1;
      check("halt_flag", halted, 1);
      check("halt_run", running, 0);
      check("halt_pc", imem_addr, m_pc);
      check("halt_imm_hold", dp_imm, ins[2:0]);
      check("halt_we", dp_we, 0);
    end else if (step_mode) begin
      step_wait();
    end
  endtask
  task automatic resume();
    int idle = noise ? $urandom_range(0, 2) : 0;
    for (int i = 0; i < idle; i++) begin
      start = 0;
      step = 1'($urandom_range(0, 1));
      halt_req = 1'($urandom_range(0, 1));
      imem_ready = 1'($urandom_range(0, 1));
      check("hold_halted", halted, m_halted);
      check("hold_req", imem_req, 0);
      tick();
    end
    start = 1;
    step = 0;
    halt_req = 0;
    tick();
    start = 0;
    m_halted = 0;
  endtask
  initial begin
    noise = 0;
    sw_mode = 0;
    m_halted = 0;
    m_pc = 0;
    m_cf = 0;
    rst = 1;
    start = 0;
    halt_req = 0;
    step_mode = 0;
    step = 0;
    imem_ready = 0;
    cf = 0;
    zf = 0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h30;
    mem[0] = 8'h0D;
    mem[2] = 8'hA6;
    mem[3] = 8'hC5;
    mem[4] = 8'h10;
    mem[5] = 8'hC3;
    mem[6] = 8'hB0;
    mem[8] = 8'h00;
    mem[9] = 8'hC3;
    tick();
    tick();
    rst = 0;
    check("rst_req", imem_req, 0);
    check("rst_we", dp_we, 0);
    check("rst_dst", dp_dst, 0);
    check("rst_sreg", dp_sreg, 0);
    check("rst_imm", dp_imm, 0);
    check("rst_run", running, 0);
    check("rst_halted", halted, 0);
    check("rst_pc", imem_addr, 0);
    resume();
    run_instr(0, 0);
    check("first_pc", imem_addr, 1);
    run_instr(0, 0);
    run_instr(0, 0);
    check("jmp_pc", imem_addr, 6);
    run_instr(0, 0);
    check("hlt_pc", imem_addr, 7);
    resume();
    run_instr(0, 0);
    run_instr(0, 1);
    run_instr(0, 0);
    check("jcf_taken_pc", imem_addr, 3);
    run_instr(0, 0);
    check("jcf_cleared_pc", imem_addr, 4);
    run_instr(0, 0);
    run_instr(0, 0);
    check("jcf_fall_pc", imem_addr, 6);
    run_instr(0, 0);
    resume();
    run_instr(3, 0);
    mem[8] = 8'h30;
    mem[9] = 8'h30;
    for (int i = 0; i < 8; i++) run_instr(i % 2, 0);
    check("wrap_pc", imem_addr, 0);
    for (int i = 0; i < 16; i++) mem[i] = 8'h05 + 8'(i % 3) * 8'h10;
    step_mode = 1;
    sw_mode = 1;
    repeat (3) run_instr(1, -1);
    sw_mode = 2;
    run_instr(0, -1);
    step_mode = 0;
    sw_mode = 0;
    resume();
    imem_ready = 0;
    tick();
    check("pre_rst_req", imem_req, 1);
    rst = 1;
    imem_ready = 1;
    tick();
    rst = 0;
    imem_ready = 0;
    m_pc = 0;
    m_cf = 0;
    m_halted = 0;
    check("midrst_pc", imem_addr, 0);
    check("midrst_we", dp_we, 0);
    check("midrst_req", imem_req, 0);
    check("midrst_run", running, 0);
    check("midrst_ir", dp_dst, 0);
    tick();
    check("midrst_we2", dp_we, 0);
    check("midrst_run2", running, 0);
    noise = 1;
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    resume();
    for (int n = 0; n < 400; n++) begin
      step_mode = $urandom_range(0, 3) == 0;
      run_instr($urandom_range(0, 3), -1);
      if (m_halted) begin
        if ($urandom_range(0, 1) == 1) for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        resume();
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/k2_sequencer.md
# k2_sequencer

Fetch/execute controller for the 8-bit K2 datapath. It owns the program counter and fetches instructions from an instruction memory through a req/ready handshake. It decodes each instruction into the datapath controls: register-write strobe, destination select, source select and immediate. It also resolves unconditional and carry-conditional jumps using a latched carry flag, and supports run, halt and single-step operation.

## Interface
Parameters:
- ADDR_W, 4: PC / instruction-address width; must be ≥ 3.
- INSTR_W, 8: instruction width; fixed field map below.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  leave IDLE/HALT and begin fetching at the current PC.
- halt_req  in  1  stop at the next instruction boundary.
- step_mode  in  1  when 1, pause after every instruction.
- step  in  1  in STEP_WAIT, a 1-cycle pulse advances one instruction.
- imem_addr  out  ADDR_W  fetch address, equal to pc.
- imem_req  out  1  fetch request.
- imem_ready  in  1  memory has valid imem_data this cycle.
- imem_data  in  INSTR_W  instruction word.
- cf  in  1  ALU carry; valid during EXEC.
- zf  in  1  ALU zero; valid during EXEC.
- dp_we  out  1  one-cycle datapath register-write strobe.
- dp_dst  out  2  destination: 00 RA, 01 RB, 10 RO.
- dp_sreg  out  1  source select: 1 immediate, 0 ALU result.
- dp_imm  out  3  immediate / ALU op field.
- running  out  1  state is FETCH, EXEC or STEP_WAIT.
- halted  out  1  state is HALT.

## Operation
- Field map: [7] J, [6] C, [5:4] D, [3] Sreg, [2:0] imm.
- Instruction classes:
  - J=0: data op. If D≠11, dp_we=1 and dp_dst=D. If D=11, it is a NOP with no write.
  - J=1, C=0, D≠11: JMP. pc ← zero-extended imm.
  - J=1, C=1, D≠11: JCF. If cf_q=1, pc ← imm and cf_q ← 0. Otherwise pc ← pc+1.
  - J=1, D=11: HLT. pc ← pc+1, then HALT.
- Flag latching:
  - cf_q and zf_q load from cf and zf in EXEC of data ops with D≠11.
  - Jumps and NOPs leave them unchanged.
  - The only clear is a taken JCF.
- States: IDLE, FETCH, EXEC, STEP_WAIT, HALT.
  - IDLE → FETCH on start.
  - FETCH: imem_req=1, imem_addr=pc. On imem_ready, ir ← imem_data and go to EXEC. Otherwise stay.
  - EXEC: drive decoded controls, update pc, latch flags. Next state is chosen in this priority order:
    1. HLT or halt_req → HALT.
    2. step_mode → STEP_WAIT.
    3. Otherwise → FETCH.
  - STEP_WAIT → FETCH on step. STEP_WAIT → HALT on halt_req; halt_req wins if both arrive together.
  - HALT → FETCH on start; pc is preserved, so execution resumes.
- PC arithmetic: pc+1 is modulo 2^ADDR_W, so 2^ADDR_W−1 wraps to 0. Jump targets are restricted to 0..7.
- dp_we, dp_dst, dp_sreg and dp_imm are meaningful only in EXEC. Outside EXEC, dp_we=0 and the other three hold the ir fields.

## Timing
- Reset values:
  - state IDLE, pc 0, ir 0.
  - cf_q 0, zf_q 0.
  - imem_req 0, dp_we 0, dp_dst 00, dp_sreg 0, dp_imm 000.
  - running 0, halted 0.
- Reset asserted mid-fetch or mid-EXEC aborts the instruction on that edge. No dp_we is issued afterward.
- Each instruction takes 2 cycles with zero-wait memory: FETCH (ready=1), then EXEC. Each ready-low cycle adds one cycle.
- imem_req stays high until ready. imem_addr is stable while req=1.
- Ready seen outside FETCH is ignored.
- start has effect only in IDLE or HALT. step has effect only in STEP_WAIT.
- halt_req is sampled only in EXEC and STEP_WAIT. A request arriving mid-fetch is honoured at the end of that instruction, provided it is still asserted.

## Structure
- Package k2_pkg holds:
  - state_t enum;
  - field bit positions;
  - DST_RA/RB/RO/NONE constants;
  - a typedef for the decoded instruction struct.
- Sub-module k2_instr_decode: combinational, ir → {is_data, is_jmp, is_jcf, is_hlt, dst, sreg, imm}.
- The PC may reuse the existing Counter_nBit with a load port. The FSM stays in k2_sequencer.

## Test plan
- Reset, then start, with always-ready memory holding 0x0D at address 0:
  - pc goes 0→1.
  - dp_we=1, dp_dst=00, dp_sreg=1, dp_imm=101 in cycle 2.
  - imem_req=1 in cycle 1.
- JMP: 0xA6 at address 2 → pc=6 after EXEC, no dp_we. Then 0xB0 (HLT) at address 6 → halted=1, pc=7. Pulsing start afterwards fetches address 7.
- JCF both ways:
  - Data op with cf=1, then 0xC3 → pc=3 and cf_q cleared.
  - Repeat with cf=0 → pc increments.
  - Repeat JCF with cf_q already 0 → falls through.
- Wait states: ready low for 3 cycles → imem_req and imem_addr held for 4 cycles, exactly one EXEC. Also set pc=2^ADDR_W−1 with a NOP → pc wraps to 0.
- Single-step:
  - step_mode=1 → STEP_WAIT after each EXEC; each step pulse yields exactly one EXEC.
  - halt_req and step in the same cycle → HALT.
  - rst asserted during FETCH → IDLE, pc=0, no dp_we.
